vram_sync_ctrl: RTL and testbench
=================================

# vram_sync_ctrl

Schedules the CPU-facing to PPU-facing VRAM copy (frame commit) and arbitrates the CPU-facing VRAM port A between CPU writes and the sync writer. It sits between the HPS/CPU register bridge, the PPU timing generator and the sync writer. A CPU commit request is held until the next vertical blank. The controller then revokes CPU write access, issues the single-cycle `sync` pulse, waits for the writer's `done`, and returns port A ownership to the CPU.

## Interface
Parameters:
- DRAIN_CYCLES, 1: cycles between revoking CPU access and pulsing `sync`; lets an in-flight CPU write land (range 1..15).
- STAT_WIDTH, 16: width of the statistics counters (only used with VRAM_SYNC_STATS_EN).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- cpu_sync_req  in  1  single-cycle commit request from the CPU register bridge
- cpu_wr_valid  in  1  CPU write to CPU-facing VRAM pending
- cpu_wr_ready  out  1  CPU write accepted this cycle; low while the sync writer owns port A
- vblank  in  1  level, high during vertical blank
- sync  out  1  single-cycle start pulse to the sync writer
- sync_done  in  1  single-cycle completion pulse from the sync writer
- portA_sel  out  1  CPU-facing port A mux select: 0 = CPU, 1 = sync writer
- req_pending  out  1  a commit is latched and not yet started
- sync_active  out  1  a copy is in progress (PPU-facing VRAM contents not stable)
- err_overrun  out  1  sticky: vblank fell while a copy was in progress
- err_clr  in  1  clears err_overrun
- sync_count  out  STAT_WIDTH  completed commits (stats build only)
- coalesce_count  out  STAT_WIDTH  requests merged into an already pending commit (stats build only)

## Operation
- States: IDLE, ARMED, DRAIN, SYNC, RELEASE.
- vblank_rise = vblank & ~vblank_q, where vblank_q is registered.
- IDLE: on cpu_sync_req → ARMED, req_pending=1.
- ARMED: on vblank_rise → DRAIN; portA_sel=1, cpu_wr_ready=0, req_pending=0, drain counter loaded with DRAIN_CYCLES-1.
- ARMED with vblank already high and no rise: keep waiting for the next rise. A commit never starts mid-vblank.
- DRAIN: counter reaches 0 → SYNC, with `sync` high for exactly the cycle of that transition.
- SYNC: on sync_done → RELEASE.
- RELEASE: one cycle with portA_sel=0, then cpu_wr_ready follows IDLE/ARMED rules. Next state is ARMED if a request was latched during the copy, else IDLE.
- cpu_wr_ready = (portA_sel==0) in IDLE and ARMED. CPU writes are never dropped, only stalled.
- cpu_sync_req in ARMED: coalesced (coalesce_count+1).
- cpu_sync_req in DRAIN, SYNC or RELEASE: latched as the next pending request; req_pending rises the following cycle.
- sync_active = 1 in DRAIN and SYNC.
- vblank falling (vblank_q & ~vblank) while in SYNC: err_overrun set. The copy still runs to sync_done; there is no abort.
- err_clr and a new overrun in the same cycle: set wins.
- sync_done outside SYNC: ignored.
- Counters wrap at 2^STAT_WIDTH.

## Timing
- Reset values: state IDLE; portA_sel=0, cpu_wr_ready=1, sync=0, req_pending=0, sync_active=0, err_overrun=0, counters 0.
- cpu_sync_req at cycle t → req_pending=1 at t+1.
- vblank rises at cycle v (sampled) → portA_sel=1 and cpu_wr_ready=0 at v+1.
- `sync` is high at v+1+DRAIN_CYCLES-1+1, i.e. v+1+DRAIN_CYCLES, for one cycle.
- sync_done at cycle d → RELEASE at d+1 → cpu_wr_ready=1 at d+2.
- sync_count increments at d+1.
- All outputs are registered; no combinational path from any input to any output.
- Reset mid-copy: controller returns to IDLE immediately and the pending request is lost. The sync writer shares rst_n.

## Configuration
- VRAM_SYNC_STATS_EN defined: sync_count and coalesce_count are implemented.
- Undefined: both ports are tied to 0 and no counter flops are built.

## Structure
- Shared package vram_pkg holds:
  - the state enum type `vram_sync_state_t`;
  - the constant `VRAM_SYNC_DRAIN_DEFAULT = 1`.
- No sub-module; one FSM plus drain counter, overrun logic and optional counters.

## Test plan
- Reset, no stimulus → portA_sel=0, cpu_wr_ready=1, sync never asserted over 1000 cycles.
- cpu_sync_req at cycle 10, vblank rises at cycle 50, DRAIN_CYCLES=1 → cpu_wr_ready=0 at 51, sync pulse at 52, sync_done at 80 → cpu_wr_ready=1 at 82, sync_count=1.
- Three cpu_sync_req pulses before one vblank → exactly one sync pulse, coalesce_count=2.
- cpu_sync_req during SYNC → after RELEASE state is ARMED, next vblank produces a second sync pulse.
- vblank falls before sync_done → err_overrun=1 and stays 1 until err_clr; err_clr plus overrun in the same cycle → remains 1.
- cpu_wr_valid held high across a commit → no write accepted between portA_sel rise and RELEASE+1; every stalled write is accepted afterwards; rst_n low mid-SYNC → all outputs at reset values next cycle.

Source files
------------

// File: rtl/vram_pkg.sv
// Shared types and constants for the VRAM frame-commit controller.
package vram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_DRAIN   = 3'd2,
        ST_SYNC    = 3'd3,
        ST_RELEASE = 3'd4
    } vram_sync_state_t;

    localparam int unsigned VRAM_SYNC_DRAIN_DEFAULT = 1;

endpackage

// File: rtl/vram_sync_ctrl.sv
// Frame-commit scheduler and port A arbiter between CPU writes and the sync writer.
// Define VRAM_SYNC_STATS_EN to build the sync_count / coalesce_count statistics.
//
// state   | meaning
// IDLE    | CPU owns port A, no commit pending
// ARMED   | commit latched, waiting for the next vblank rising edge
// DRAIN   | CPU access revoked, letting an in-flight CPU write land
// SYNC    | sync writer copying, waiting for sync_done
// RELEASE | one cycle handing port A back to the CPU
module vram_sync_ctrl
    import vram_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = VRAM_SYNC_DRAIN_DEFAULT,
    parameter int unsigned STAT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_sync_req,
    input  logic                  cpu_wr_valid,
    output logic                  cpu_wr_ready,
    input  logic                  vblank,
    output logic                  sync,
    input  logic                  sync_done,
    output logic                  portA_sel,
    output logic                  req_pending,
    output logic                  sync_active,
    output logic                  err_overrun,
    input  logic                  err_clr,
    output logic [STAT_WIDTH-1:0] sync_count,
    output logic [STAT_WIDTH-1:0] coalesce_count
);

    vram_sync_state_t state_q, state_d;
    logic [3:0] drain_cnt_q, drain_cnt_d;
    logic       next_req_q, next_req_d;
    logic       vblank_q;
    logic       sync_q, sync_d;
    logic       wr_ready_q, sel_q, pend_q, active_q, err_q, err_d;
    logic       coalesce_evt, done_evt;
    logic       vblank_rise, vblank_fall;

    // The CPU side is only stalled through cpu_wr_ready; the valid itself needs no decode.
    logic unused_wr_valid;
    assign unused_wr_valid = cpu_wr_valid;

    assign vblank_rise = vblank & ~vblank_q;
    assign vblank_fall = vblank_q & ~vblank;

    always_comb begin
        state_d      = state_q;
        drain_cnt_d  = drain_cnt_q;
        next_req_d   = next_req_q;
        sync_d       = 1'b0;
        coalesce_evt = 1'b0;
        done_evt     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cpu_sync_req) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                coalesce_evt = cpu_sync_req;
                if (vblank_rise) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = 4'(DRAIN_CYCLES - 1);
                end
            end
            ST_DRAIN: begin
                coalesce_evt = cpu_sync_req & next_req_q;
                next_req_d   = next_req_q | cpu_sync_req;
                if (drain_cnt_q == 4'd0) begin
                    state_d = ST_SYNC;
                    sync_d  = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q - 4'd1;
                end
            end
            ST_SYNC: begin
                coalesce_evt = cpu_sync_req & next_req_q;
                next_req_d   = next_req_q | cpu_sync_req;
                if (sync_done) begin
                    state_d  = ST_RELEASE;
                    done_evt = 1'b1;
                end
            end
            ST_RELEASE: begin
                coalesce_evt = cpu_sync_req & next_req_q;
                next_req_d   = 1'b0;
                state_d      = (next_req_q | cpu_sync_req) ? ST_ARMED : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Overrun set has priority over a same-cycle clear.
    assign err_d = (vblank_fall && state_q == ST_SYNC) ? 1'b1 : (err_clr ? 1'b0 : err_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            drain_cnt_q <= 4'd0;
            next_req_q  <= 1'b0;
            vblank_q    <= 1'b0;
            sync_q      <= 1'b0;
            wr_ready_q  <= 1'b1;
            sel_q       <= 1'b0;
            pend_q      <= 1'b0;
            active_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            next_req_q  <= next_req_d;
            vblank_q    <= vblank;
            sync_q      <= sync_d;
            wr_ready_q  <= (state_d == ST_IDLE) || (state_d == ST_ARMED);
            sel_q       <= (state_d == ST_DRAIN) || (state_d == ST_SYNC);
            pend_q      <= (state_d == ST_ARMED) || next_req_d;
            active_q    <= (state_d == ST_DRAIN) || (state_d == ST_SYNC);
            err_q       <= err_d;
        end
    end

    assign cpu_wr_ready = wr_ready_q;
    assign sync         = sync_q;
    assign portA_sel    = sel_q;
    assign req_pending  = pend_q;
    assign sync_active  = active_q;
    assign err_overrun  = err_q;

`ifdef VRAM_SYNC_STATS_EN
    logic [STAT_WIDTH-1:0] sync_cnt_q, coal_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_cnt_q <= '0;
            coal_cnt_q <= '0;
        end else begin
            if (done_evt)     sync_cnt_q <= sync_cnt_q + 1'b1;
            if (coalesce_evt) coal_cnt_q <= coal_cnt_q + 1'b1;
        end
    end

    assign sync_count     = sync_cnt_q;
    assign coalesce_count = coal_cnt_q;
`else
    logic unused_stat_evts;
    assign unused_stat_evts = done_evt | coalesce_evt;
    assign sync_count       = '0;
    assign coalesce_count   = '0;
`endif

endmodule

// File: tb/tb_vram_sync_ctrl.sv
// Directed bench for vram_sync_ctrl with DRAIN_CYCLES at its default of 1.
module tb_vram_sync_ctrl;

`ifdef VRAM_SYNC_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, cpu_sync_req, cpu_wr_valid, vblank, sync_done, err_clr;
    logic        cpu_wr_ready, sync, portA_sel, req_pending, sync_active, err_overrun;
    logic [15:0] sync_count, coalesce_count;

    int          vec_cnt = 0;
    int          err_cnt = 0;
    logic [15:0] exp_sync = '0;
    logic [15:0] exp_coal = '0;
    logic [15:0] exp_v;

    always #5 clk = ~clk;

    vram_sync_ctrl dut (
        .clk(clk), .rst_n(rst_n), .cpu_sync_req(cpu_sync_req), .cpu_wr_valid(cpu_wr_valid),
        .cpu_wr_ready(cpu_wr_ready), .vblank(vblank), .sync(sync), .sync_done(sync_done),
        .portA_sel(portA_sel), .req_pending(req_pending), .sync_active(sync_active),
        .err_overrun(err_overrun), .err_clr(err_clr), .sync_count(sync_count),
        .coalesce_count(coalesce_count)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Request a commit from IDLE with vblank low; returns in the first SYNC cycle.
    task automatic start_to_sync;
        cpu_sync_req = 1'b1; tick; cpu_sync_req = 1'b0;
        tick;
        vblank = 1'b1; tick;
        tick;
    endtask

    task automatic test_reset;
        int seen_sync, seen_sel, seen_stall;
        rst_n = 1'b0; cpu_sync_req = 0; cpu_wr_valid = 0; vblank = 0; sync_done = 0; err_clr = 0;
        tick; tick;
        vec_cnt++; if (cpu_wr_ready !== 1'b1) begin err_cnt++; $display("FAIL reset_wr_ready got %b exp 1", cpu_wr_ready); end
        vec_cnt++; if (portA_sel !== 1'b0) begin err_cnt++; $display("FAIL reset_portA_sel got %b exp 0", portA_sel); end
        vec_cnt++; if ({sync, req_pending, sync_active, err_overrun} !== 4'b0000) begin err_cnt++; $display("FAIL reset_flags got %b exp 0000", {sync, req_pending, sync_active, err_overrun}); end
        vec_cnt++; if ({sync_count, coalesce_count} !== 32'd0) begin err_cnt++; $display("FAIL reset_counters got %h exp 0", {sync_count, coalesce_count}); end
        rst_n = 1'b1;
        seen_sync = 0; seen_sel = 0; seen_stall = 0;
        for (int i = 0; i < 1000; i++) begin
            tick;
            if (sync) seen_sync++;
            if (portA_sel) seen_sel++;
            if (!cpu_wr_ready) seen_stall++;
        end
        vec_cnt++; if (seen_sync != 0) begin err_cnt++; $display("FAIL idle_sync got %0d pulses exp 0", seen_sync); end
        vec_cnt++; if (seen_sel + seen_stall != 0) begin err_cnt++; $display("FAIL idle_port got sel=%0d stall=%0d exp 0", seen_sel, seen_stall); end
    endtask

    task automatic test_basic_commit;
        repeat (9) tick;
        cpu_sync_req = 1'b1; tick; cpu_sync_req = 1'b0;
        vec_cnt++; if (req_pending !== 1'b1) begin err_cnt++; $display("FAIL basic_pending got %b exp 1", req_pending); end
        vec_cnt++; if ({portA_sel, cpu_wr_ready} !== 2'b01) begin err_cnt++; $display("FAIL basic_armed_port got %b exp 01", {portA_sel, cpu_wr_ready}); end
        repeat (39) tick;
        vblank = 1'b1; tick;
        vec_cnt++; if ({portA_sel, cpu_wr_ready, req_pending, sync_active, sync} !== 5'b10010) begin err_cnt++; $display("FAIL basic_drain got %b exp 10010", {portA_sel, cpu_wr_ready, req_pending, sync_active, sync}); end
        tick;
        vec_cnt++; if ({sync, sync_active} !== 2'b11) begin err_cnt++; $display("FAIL basic_sync_pulse got %b exp 11", {sync, sync_active}); end
        tick;
        vec_cnt++; if (sync !== 1'b0) begin err_cnt++; $display("FAIL basic_sync_width got %b exp 0", sync); end
        repeat (26) tick;
        sync_done = 1'b1; tick; sync_done = 1'b0;
        exp_sync++;
        vec_cnt++; if ({portA_sel, cpu_wr_ready, sync_active} !== 3'b000) begin err_cnt++; $display("FAIL basic_release got %b exp 000", {portA_sel, cpu_wr_ready, sync_active}); end
        exp_v = STATS ? exp_sync : 16'd0;
        vec_cnt++; if (sync_count !== exp_v) begin err_cnt++; $display("FAIL basic_sync_count got %0d exp %0d", sync_count, exp_v); end
        tick;
        vec_cnt++; if ({cpu_wr_ready, req_pending} !== 2'b10) begin err_cnt++; $display("FAIL basic_idle_after got %b exp 10", {cpu_wr_ready, req_pending}); end
        vblank = 1'b0; tick;
        vec_cnt++; if (err_overrun !== 1'b0) begin err_cnt++; $display("FAIL basic_no_overrun got %b exp 0", err_overrun); end
    endtask

    task automatic test_coalesce;
        int pulses;
        vblank = 1'b1; tick;
        for (int i = 0; i < 3; i++) begin
            cpu_sync_req = 1'b1; tick; cpu_sync_req = 1'b0;
            repeat (3) tick;
        end
        exp_coal = exp_coal + 16'd2;
        vec_cnt++; if ({req_pending, portA_sel} !== 2'b10) begin err_cnt++; $display("FAIL coal_mid_vblank got %b exp 10", {req_pending, portA_sel}); end
        vblank = 1'b0; tick;
        vblank = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (sync) pulses++;
        end
        vec_cnt++; if (pulses != 1) begin err_cnt++; $display("FAIL coal_pulses got %0d exp 1", pulses); end
        exp_v = STATS ? exp_coal : 16'd0;
        vec_cnt++; if (coalesce_count !== exp_v) begin err_cnt++; $display("FAIL coal_count got %0d exp %0d", coalesce_count, exp_v); end
        sync_done = 1'b1; tick; sync_done = 1'b0;
        exp_sync++;
        tick;
        vec_cnt++; if ({cpu_wr_ready, req_pending} !== 2'b10) begin err_cnt++; $display("FAIL coal_idle_after got %b exp 10", {cpu_wr_ready, req_pending}); end
        vblank = 1'b0; tick;
    endtask

    task automatic test_req_during_sync;
        start_to_sync;
        cpu_sync_req = 1'b1; tick; cpu_sync_req = 1'b0;
        vec_cnt++; if ({req_pending, sync_active} !== 2'b11) begin err_cnt++; $display("FAIL rds_latch got %b exp 11", {req_pending, sync_active}); end
        repeat (3) tick;
        sync_done = 1'b1; tick; sync_done = 1'b0;
        exp_sync++;
        vec_cnt++; if ({portA_sel, req_pending} !== 2'b01) begin err_cnt++; $display("FAIL rds_release got %b exp 01", {portA_sel, req_pending}); end
        tick;
        vec_cnt++; if ({cpu_wr_ready, req_pending, portA_sel} !== 3'b110) begin err_cnt++; $display("FAIL rds_armed got %b exp 110", {cpu_wr_ready, req_pending, portA_sel}); end
        repeat (3) tick;
        vec_cnt++; if ({sync, portA_sel} !== 2'b00) begin err_cnt++; $display("FAIL rds_no_midvblank got %b exp 00", {sync, portA_sel}); end
        vblank = 1'b0; tick;
        vblank = 1'b1; tick;
        vec_cnt++; if (portA_sel !== 1'b1) begin err_cnt++; $display("FAIL rds_second_drain got %b exp 1", portA_sel); end
        tick;
        vec_cnt++; if (sync !== 1'b1) begin err_cnt++; $display("FAIL rds_second_sync got %b exp 1", sync); end
        sync_done = 1'b1; tick; sync_done = 1'b0;
        exp_sync++;
        tick;
        vec_cnt++; if ({cpu_wr_ready, req_pending} !== 2'b10) begin err_cnt++; $display("FAIL rds_idle_after got %b exp 10", {cpu_wr_ready, req_pending}); end
        exp_v = STATS ? exp_sync : 16'd0;
        vec_cnt++; if (sync_count !== exp_v) begin err_cnt++; $display("FAIL rds_sync_count got %0d exp %0d", sync_count, exp_v); end
        vblank = 1'b0; tick;
    endtask

    task automatic test_overrun;
        start_to_sync;
        vblank = 1'b0; tick;
        vec_cnt++; if ({err_overrun, sync_active, portA_sel} !== 3'b111) begin err_cnt++; $display("FAIL ovr_set got %b exp 111", {err_overrun, sync_active, portA_sel}); end
        repeat (2) tick;
        sync_done = 1'b1; tick; sync_done = 1'b0;
        exp_sync++;
        vec_cnt++; if ({err_overrun, portA_sel} !== 2'b10) begin err_cnt++; $display("FAIL ovr_release got %b exp 10", {err_overrun, portA_sel}); end
        tick; tick;
        vec_cnt++; if (err_overrun !== 1'b1) begin err_cnt++; $display("FAIL ovr_sticky got %b exp 1", err_overrun); end
        start_to_sync;
        err_clr = 1'b1; vblank = 1'b0; tick; err_clr = 1'b0;
        vec_cnt++; if (err_overrun !== 1'b1) begin err_cnt++; $display("FAIL ovr_set_wins got %b exp 1", err_overrun); end
        sync_done = 1'b1; tick; sync_done = 1'b0;
        exp_sync++;
        tick;
        err_clr = 1'b1; tick; err_clr = 1'b0;
        vec_cnt++; if (err_overrun !== 1'b0) begin err_cnt++; $display("FAIL ovr_clear got %b exp 0", err_overrun); end
    endtask

    task automatic test_write_stall_and_reset;
        int busy_acc, post_acc;
        cpu_wr_valid = 1'b1;
        cpu_sync_req = 1'b1; tick; cpu_sync_req = 1'b0;
        tick;
        busy_acc = 0;
        vblank = 1'b1; tick; busy_acc += int'(cpu_wr_valid & cpu_wr_ready);
        tick; busy_acc += int'(cpu_wr_valid & cpu_wr_ready);
        for (int i = 0; i < 3; i++) begin
            tick; busy_acc += int'(cpu_wr_valid & cpu_wr_ready);
        end
        sync_done = 1'b1; tick; sync_done = 1'b0;
        exp_sync++;
        busy_acc += int'(cpu_wr_valid & cpu_wr_ready);
        vec_cnt++; if (busy_acc != 0) begin err_cnt++; $display("FAIL stall_busy got %0d accepts exp 0", busy_acc); end
        post_acc = 0;
        for (int i = 0; i < 5; i++) begin
            tick; post_acc += int'(cpu_wr_valid & cpu_wr_ready);
        end
        vec_cnt++; if (post_acc != 5) begin err_cnt++; $display("FAIL stall_resume got %0d accepts exp 5", post_acc); end
        exp_v = STATS ? exp_sync : 16'd0;
        vec_cnt++; if (sync_count !== exp_v) begin err_cnt++; $display("FAIL stall_sync_count got %0d exp %0d", sync_count, exp_v); end
        vblank = 1'b0; tick;
        start_to_sync;
        cpu_sync_req = 1'b1; tick; cpu_sync_req = 1'b0;
        rst_n = 1'b0; tick;
        vec_cnt++; if ({portA_sel, cpu_wr_ready, sync, req_pending, sync_active, err_overrun} !== 6'b010000) begin err_cnt++; $display("FAIL rst_mid_sync got %b exp 010000", {portA_sel, cpu_wr_ready, sync, req_pending, sync_active, err_overrun}); end
        vec_cnt++; if ({sync_count, coalesce_count} !== 32'd0) begin err_cnt++; $display("FAIL rst_counters got %h exp 0", {sync_count, coalesce_count}); end
        rst_n = 1'b1; vblank = 1'b0; tick;
        vblank = 1'b1; tick; tick;
        vec_cnt++; if ({req_pending, portA_sel, sync, cpu_wr_ready} !== 4'b0001) begin err_cnt++; $display("FAIL rst_req_lost got %b exp 0001", {req_pending, portA_sel, sync, cpu_wr_ready}); end
        cpu_wr_valid = 1'b0; vblank = 1'b0;
    endtask

    initial begin
        test_reset;
        test_basic_commit;
        test_coalesce;
        test_req_during_sync;
        test_overrun;
        test_write_stall_and_reset;
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
